ram_byte_loader: RTL and testbench

Upstream Wishbone master that fills the byte-enabled single-port `ram` from an 8-bit valid/ready byte stream (boot loader, UART/JTAG image download). It packs each byte into the correct 32-bit lane with a one-hot `o_wb_sel`, one write per cycle at incrementing byte addresses. Its bus outputs connect directly to the `ram` `i_wb_*` inputs, and `i_wb_rdt` connects to `ram.o_wb_rdt`.

---
 rtl/ram_byte_loader.sv | 246 ++++++++++++++++++++++++
 tb/tb_ram_byte_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_byte_loader.sv
`default_nettype none
// ============================================================================
// Module   : ram_byte_loader
// Purpose  : Wishbone master that fills a byte-enabled 32-bit RAM from an
//            8-bit valid/ready byte stream. Each accepted byte is written to
//            the next byte address using a one-hot o_wb_sel lane, at one byte
//            per cycle.
// Ports    : i_wb_clk, i_rst_n (async, active-low)
//            i_start, i_base_adr, i_len        - load request
//            i_byte_data/valid, o_byte_ready   - byte stream
//            o_wb_adr/dat/sel/we/cyc, i_wb_rdt - RAM bus
//            o_busy, o_done, o_err             - status
// Config   : RAM_LOADER_VERIFY_EN - when defined, the loaded range is read
//            back after the load and o_err flags a checksum mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module ram_byte_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_wb_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [AW-1:0] i_base_adr,
    input  logic [AW:0]   i_len,
    input  logic [7:0]    i_byte_data,
    input  logic          i_byte_valid,
    output logic          o_byte_ready,
    output logic [AW-1:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic [31:0]   i_wb_rdt,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [AW-1:0] r_base;
    logic [AW:0]   r_len;
    logic [AW:0]   r_wcnt;
    logic [15:0]   r_wsum;

    logic          w_start_acc;
    logic          w_hs;
    logic [AW-1:0] w_wadr;

    assign w_start_acc  = (r_state == S_IDLE) && i_start;
    // Ready depends on registers only, so the upstream valid never loops back.
    assign o_byte_ready = (r_state == S_LOAD) && (r_wcnt < r_len);
    assign w_hs         = o_byte_ready && i_byte_valid;
    // AW-bit addition wraps naturally modulo DEPTH.
    assign w_wadr       = r_base + r_wcnt[AW-1:0];

    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);

`ifdef RAM_LOADER_VERIFY_EN
    logic [AW:0]   r_rcnt;
    logic [15:0]   r_rsum;
    logic          r_p1_v;
    logic [1:0]    r_p1_lane;
    logic          r_p2_v;
    logic [1:0]    r_p2_lane;
    logic          r_err;
    logic          w_rd_req;
    logic          w_last_ret;
    logic [AW-1:0] w_radr;
    logic [7:0]    w_rdt_byte;
    logic [15:0]   w_rsum_next;

    assign w_rd_req   = (r_state == S_VERIFY) && (r_rcnt < r_len);
    assign w_radr     = r_base + r_rcnt[AW-1:0];
    // Final return: every read issued, the last request has moved to stage 2
    // and nothing younger is behind it.
    assign w_last_ret = (r_state == S_VERIFY) && (r_rcnt == r_len) && r_p2_v && !r_p1_v;

    always_comb begin
        w_rdt_byte = i_wb_rdt[7:0];
        case (r_p2_lane)
            2'd0: w_rdt_byte = i_wb_rdt[7:0];
            2'd1: w_rdt_byte = i_wb_rdt[15:8];
            2'd2: w_rdt_byte = i_wb_rdt[23:16];
            2'd3: w_rdt_byte = i_wb_rdt[31:24];
            default: w_rdt_byte = i_wb_rdt[7:0];
        endcase
    end

    assign w_rsum_next = r_rsum + {8'h00, w_rdt_byte};
    assign o_err       = r_err;
`else
    logic w_unused_rdt;
    assign w_unused_rdt = ^i_wb_rdt;
    assign o_err        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                // Final byte is already on the bus; it is written at this edge.
                if (r_wcnt == r_len) begin
`ifdef RAM_LOADER_VERIFY_EN
                    w_state_next = S_VERIFY;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
            S_VERIFY: begin
`ifdef RAM_LOADER_VERIFY_EN
                if (w_last_ret) begin
                    w_state_next = S_DONE;
                end
`else
                w_state_next = S_IDLE;
`endif
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered bus outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base   <= '0;
            r_len    <= '0;
            r_wcnt   <= '0;
            r_wsum   <= '0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_sel <= '0;
            o_wb_we  <= 1'b0;
            o_wb_cyc <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            o_wb_sel <= '0;
            o_wb_we  <= 1'b0;
            o_wb_cyc <= 1'b0;

            if (w_start_acc) begin
                r_base <= i_base_adr;
                r_len  <= i_len;
                r_wcnt <= '0;
                r_wsum <= '0;
            end

            if (w_hs) begin
                o_wb_adr <= w_wadr;
                o_wb_dat <= {4{i_byte_data}};
                o_wb_sel <= 4'b0001 << w_wadr[1:0];
                o_wb_we  <= 1'b1;
                o_wb_cyc <= 1'b1;
                r_wcnt   <= r_wcnt + {{AW{1'b0}}, 1'b1};
                r_wsum   <= r_wsum + {8'h00, i_byte_data};
            end

`ifdef RAM_LOADER_VERIFY_EN
            if (w_rd_req) begin
                o_wb_adr <= w_radr;
                o_wb_sel <= 4'hF;
                o_wb_we  <= 1'b0;
                o_wb_cyc <= 1'b1;
            end
`endif
        end
    end

`ifdef RAM_LOADER_VERIFY_EN
    // ------------------------------------------------------------------
    // Read-back pipeline: stage 1 is the registered request, stage 2 lines
    // up with the RAM's registered read data.
    // ------------------------------------------------------------------
    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rcnt    <= '0;
            r_rsum    <= '0;
            r_p1_v    <= 1'b0;
            r_p1_lane <= 2'd0;
            r_p2_v    <= 1'b0;
            r_p2_lane <= 2'd0;
            r_err     <= 1'b0;
        end else if (w_start_acc) begin
            r_rcnt    <= '0;
            r_rsum    <= '0;
            r_p1_v    <= 1'b0;
            r_p2_v    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_p1_v    <= w_rd_req;
            r_p1_lane <= w_radr[1:0];
            r_p2_v    <= r_p1_v;
            r_p2_lane <= r_p1_lane;
            if (w_rd_req) begin
                r_rcnt <= r_rcnt + {{AW{1'b0}}, 1'b1};
            end
            if (r_p2_v) begin
                r_rsum <= w_rsum_next;
            end
            // Compare against the sum that includes the final returned byte.
            if (w_last_ret) begin
                r_err <= (w_rsum_next != r_wsum);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_byte_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_byte_loader
// Purpose  : Directed self-checking bench for ram_byte_loader with a
//            behavioural byte-enabled RAM and bus monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_byte_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
`ifdef RAM_LOADER_VERIFY_EN
    localparam int VX = 1;
`else
    localparam int VX = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_base_adr = '0;
    logic [AW:0]   i_len = '0;
    logic [7:0]    i_byte_data = '0;
    logic          i_byte_valid = 1'b0;
    logic          o_byte_ready;
    logic [AW-1:0] o_wb_adr;
    logic [31:0]   o_wb_dat;
    logic [3:0]    o_wb_sel;
    logic          o_wb_we;
    logic          o_wb_cyc;
    logic [31:0]   rdt_dut;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    always #5 clk = ~clk;

    ram_byte_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_wb_clk    (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .i_base_adr  (i_base_adr),
        .i_len       (i_len),
        .i_byte_data (i_byte_data),
        .i_byte_valid(i_byte_valid),
        .o_byte_ready(o_byte_ready),
        .o_wb_adr    (o_wb_adr),
        .o_wb_dat    (o_wb_dat),
        .o_wb_sel    (o_wb_sel),
        .o_wb_we     (o_wb_we),
        .o_wb_cyc    (o_wb_cyc),
        .i_wb_rdt    (rdt_dut),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    // ---------------- behavioural RAM + monitors ----------------
    logic [31:0] mem [DEPTH/4];
    logic [31:0] ram_rdt = '0;
    logic        rd_pend = 1'b0;
    int          ret_cnt = 0;
    int          wr_n = 0;
    int          cyc_n = 0;
    logic [3:0]  sel_log [1024];
    int          byte_wr [DEPTH];
    bit          corrupt_en = 1'b0;
    int          corrupt_idx = 0;

    initial begin
        for (int i = 0; i < DEPTH/4; i++) mem[i] = 32'hDEAD0000 | i;
        for (int i = 0; i < DEPTH; i++) byte_wr[i] = 0;
    end

    always @(posedge clk) begin
        if (o_wb_cyc && o_wb_we) begin
            for (int l = 0; l < 4; l++)
                if (o_wb_sel[l]) mem[o_wb_adr[AW-1:2]][8*l +: 8] <= o_wb_dat[8*l +: 8];
            sel_log[wr_n % 1024] <= o_wb_sel;
            byte_wr[o_wb_adr]    <= byte_wr[o_wb_adr] + 1;
            wr_n                 <= wr_n + 1;
        end
        if (o_wb_cyc && !o_wb_we) ram_rdt <= mem[o_wb_adr[AW-1:2]];
        if (o_wb_cyc) cyc_n <= cyc_n + 1;
        rd_pend <= o_wb_cyc && !o_wb_we;
        if (rd_pend) ret_cnt <= ret_cnt + 1;
    end

    assign rdt_dut = ram_rdt ^ ((corrupt_en && rd_pend && ret_cnt == corrupt_idx) ? 32'hFFFF_FFFF : 32'h0);

    // ---------------- checking ----------------
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] tb_bytes [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input logic [7:0] base, input logic [8:0] len, input bit stall,
                            input int start_at, output int done_at, output int done_cnt,
                            output int gap_bad);
        int idx;
        int k;
        bit hs;
        bit prev_ready;
        idx = 0; done_at = -1; done_cnt = 0; gap_bad = 0;
        i_start = 1'b1; i_base_adr = base; i_len = len;
        @(posedge clk); #1;
        i_start = 1'b0;
        k = 1;
        if (o_done) begin done_cnt++; done_at = k; end
        while (k < 1200 && !(done_cnt > 0 && !o_busy)) begin
            i_byte_valid = stall ? (k % 2 == 1) : 1'b1;
            i_byte_data  = tb_bytes[idx % DEPTH];
            i_start      = (k == start_at);
            i_base_adr   = 8'h00;
            i_len        = 9'd3;
            hs           = o_byte_ready && i_byte_valid;
            prev_ready   = o_byte_ready;
            @(posedge clk); #1;
            k++;
            if (hs) idx++;
            if (prev_ready && !hs && o_wb_cyc) gap_bad++;
            if (o_done) begin done_cnt++; if (done_at < 0) done_at = k; end
        end
        i_byte_valid = 1'b0;
        i_start = 1'b0;
    endtask

    int done_at, done_cnt, gap_bad, w0, c0, bad;
    logic [31:0] snap [DEPTH/4];
    int bw0 [DEPTH];

    initial begin
        // ---------------- reset state ----------------
        #1;
        check("reset_outputs", {o_byte_ready, o_wb_adr, o_wb_sel, o_wb_we, o_wb_cyc, o_busy, o_done, o_err},
              32'h0);
        check("reset_dat", o_wb_dat, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- reset mid-LOAD after 3 of 8 bytes ----------------
        for (int i = 0; i < 8; i++) tb_bytes[i] = 8'hC0 + 8'(i);
        i_start = 1'b1; i_base_adr = 8'h20; i_len = 9'd8;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("start_ready", {31'h0, o_byte_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            i_byte_valid = 1'b1; i_byte_data = tb_bytes[i];
            @(posedge clk); #1;
        end
        i_byte_valid = 1'b0;
        check("pre_reset_strobe", {30'h0, o_wb_cyc, o_wb_we}, 32'h3);
        rst_n = 1'b0;
        #1;
        check("midload_reset_outputs",
              {o_byte_ready, o_wb_adr, o_wb_sel, o_wb_we, o_wb_cyc, o_busy, o_done, o_err}, 32'h0);
        check("midload_reset_dat", o_wb_dat, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("dropped_byte_word8", mem[8], 32'hDEADC1C0);
        for (int i = 0; i < DEPTH/4; i++) snap[i] = mem[i];
        tb_bytes[0] = 8'h11; tb_bytes[1] = 8'h22; tb_bytes[2] = 8'h33; tb_bytes[3] = 8'h44;
        run_load(8'h10, 9'd4, 1'b0, -1, done_at, done_cnt, gap_bad);
        check("after_reset_word4", mem[4], 32'h44332211);
        bad = 0;
        for (int i = 0; i < DEPTH/4; i++) if (i != 4 && mem[i] !== snap[i]) bad++;
        check("after_reset_other_words", bad, 0);

        // ---------------- unaligned load ----------------
        for (int i = 0; i < 6; i++) tb_bytes[i] = 8'hA0 + 8'(i);
        w0 = wr_n;
        run_load(8'h05, 9'd6, 1'b0, -1, done_at, done_cnt, gap_bad);
        check("unaligned_writes", wr_n - w0, 6);
        check("unaligned_sel_seq",
              {8'h0, sel_log[w0], sel_log[w0+1], sel_log[w0+2], sel_log[w0+3], sel_log[w0+4], sel_log[w0+5]},
              32'h00248124);
        check("unaligned_word1", mem[1], 32'hA2A1A001);
        check("unaligned_word2", mem[2], 32'hDEA5A4A3);
        check("unaligned_done_cycle", done_at, 8 + VX * 8);
        check("unaligned_err", {31'h0, o_err}, 32'h0);

        // ---------------- wrap-around ----------------
        for (int i = 0; i < 4; i++) tb_bytes[i] = 8'h01 + 8'(i);
        run_load(8'hFE, 9'd4, 1'b0, -1, done_at, done_cnt, gap_bad);
        check("wrap_hi_bytes", {16'h0, mem[63][31:16]}, 32'h0201);
        check("wrap_lo_bytes", {16'h0, mem[0][15:0]}, 32'h0403);

        // ---------------- stalled stream + ignored start ----------------
        tb_bytes[0] = 8'h5A; tb_bytes[1] = 8'h6B; tb_bytes[2] = 8'h7C; tb_bytes[3] = 8'h8D;
        w0 = wr_n;
        run_load(8'h30, 9'd4, 1'b1, 3, done_at, done_cnt, gap_bad);
        check("stall_gap_cyc", gap_bad, 0);
        check("stall_writes", wr_n - w0, 4);
        check("stall_done_once", done_cnt, 1);
        check("stall_done_cycle", done_at, 9 + VX * 6);
        check("stall_word12", mem[12], 32'h8D7C6B5A);

        // ---------------- len = 0 ----------------
        c0 = cyc_n;
        run_load(8'h44, 9'd0, 1'b0, -1, done_at, done_cnt, gap_bad);
        check("len0_done_cycle", done_at, 1);
        check("len0_no_bus", cyc_n - c0, 0);
        check("len0_done_once", done_cnt, 1);

`ifdef RAM_LOADER_VERIFY_EN
        // ---------------- verify: clean, corrupted, clear ----------------
        for (int i = 0; i < 8; i++) tb_bytes[i] = 8'h90 + 8'(i);
        run_load(8'h40, 9'd8, 1'b0, -1, done_at, done_cnt, gap_bad);
        check("verify_clean_err", {31'h0, o_err}, 32'h0);
        check("verify_done_cycle", done_at, 20);
        corrupt_idx = ret_cnt + 2;
        corrupt_en  = 1'b1;
        run_load(8'h40, 9'd8, 1'b0, -1, done_at, done_cnt, gap_bad);
        corrupt_en  = 1'b0;
        check("verify_corrupt_err", {31'h0, o_err}, 32'h1);
        i_start = 1'b1; i_base_adr = 8'h00; i_len = 9'd0;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("verify_err_cleared", {31'h0, o_err}, 32'h0);
        @(posedge clk); #1;
`endif

        // ---------------- full-memory load ----------------
        for (int i = 0; i < DEPTH; i++) begin
            tb_bytes[i] = 8'(i) ^ 8'h3C;
            bw0[i] = byte_wr[i];
        end
        run_load(8'h80, 9'd256, 1'b0, -1, done_at, done_cnt, gap_bad);
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (byte_wr[a] - bw0[a] != 1) bad++;
        check("full_each_byte_once", bad, 0);
        bad = 0;
        for (int a = 0; a < DEPTH; a++)
            if (mem[a/4][8*(a%4) +: 8] !== (8'((a - 128) & 255) ^ 8'h3C)) bad++;
        check("full_contents", bad, 0);
        check("full_done_cycle", done_at, 258 + VX * 258);
        check("full_idle_after", {31'h0, o_busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
